// File: rtl/rsa_uart_wrapper.sv
// Avalon-MM master that feeds the RSA-256 core from a polled UART.
// It loads n and d once per reset, then keeps decrypting cipher blocks and returns 31 plaintext bytes for each one.
module rsa_uart_wrapper #(
    parameter logic [4:0] RX_BASE     = 5'h00,
    parameter logic [4:0] TX_BASE     = 5'h04,
    parameter logic [4:0] STATUS_BASE = 5'h08,
    parameter int         RX_OK_BIT   = 7,
    parameter int         TX_OK_BIT   = 6,
    parameter int         IN_BYTES    = 32,
    parameter int         OUT_BYTES   = 31
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_a_pow_d,
    input  logic         i_core_finished
);

    // state       | meaning
    // S_QUERY_RX  | poll status until an RX byte is available
    // S_READ      | read one RX byte into the current phase register
    // S_START     | request the one-cycle core start pulse
    // S_WAIT_CORE | wait for the core result
    // S_QUERY_TX  | poll status until TX can accept a byte
    // S_WRITE     | write the next plaintext byte
    typedef enum logic [2:0] {
        S_QUERY_RX,
        S_READ,
        S_START,
        S_WAIT_CORE,
        S_QUERY_TX,
        S_WRITE
    } state_t;

    typedef enum logic [1:0] {
        PH_N,
        PH_D,
        PH_A
    } phase_t;

    localparam logic [5:0] IN_LAST  = 6'(IN_BYTES - 1);
    localparam logic [5:0] OUT_LAST = 6'(OUT_BYTES - 1);

    state_t        state, state_nxt;
    phase_t        phase, phase_nxt;
    logic [5:0]    cnt, cnt_nxt;
    logic          read_nxt, write_nxt, start_nxt;
    logic [4:0]    addr_nxt;
    logic [31:0]   wdata_nxt;
    logic          shift_in, load_out, shift_out;
    logic          xfer_done;
    logic [255:0]  n_reg, d_reg, a_reg;
    logic [247:0]  out_reg;

    assign o_core_n  = n_reg;
    assign o_core_d  = d_reg;
    assign o_core_a  = a_reg;
    assign xfer_done = (avm_read || avm_write) && !avm_waitrequest;

    // The top result byte is never transmitted, and only the low byte of readdata carries data.
    logic unused_bits;
    assign unused_bits = ^{avm_readdata[31:8], i_core_a_pow_d[255:248]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_QUERY_RX;
            phase         <= PH_N;
            cnt           <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            o_core_start  <= 1'b0;
        end else begin
            state         <= state_nxt;
            phase         <= phase_nxt;
            cnt           <= cnt_nxt;
            avm_read      <= read_nxt;
            avm_write     <= write_nxt;
            avm_address   <= addr_nxt;
            avm_writedata <= wdata_nxt;
            o_core_start  <= start_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        read_nxt  = avm_read;
        write_nxt = avm_write;
        addr_nxt  = avm_address;
        wdata_nxt = avm_writedata;
        start_nxt = 1'b0;
        shift_in  = 1'b0;
        load_out  = 1'b0;
        shift_out = 1'b0;

        case (state)
            S_QUERY_RX: begin
                if (!avm_read) begin
                    read_nxt = 1'b1;
                    addr_nxt = STATUS_BASE;
                end else if (xfer_done) begin
                    read_nxt = 1'b0;
                    if (avm_readdata[RX_OK_BIT]) state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (!avm_read) begin
                    read_nxt = 1'b1;
                    addr_nxt = RX_BASE;
                end else if (xfer_done) begin
                    read_nxt  = 1'b0;
                    shift_in  = 1'b1;
                    state_nxt = S_QUERY_RX;
                    if (cnt == IN_LAST) begin
                        cnt_nxt = '0;
                        case (phase)
                            PH_N:    phase_nxt = PH_D;
                            PH_D:    phase_nxt = PH_A;
                            default: begin
                                phase_nxt = PH_A;
                                state_nxt = S_START;
                            end
                        endcase
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
            end
            S_START: begin
                start_nxt = 1'b1;
                state_nxt = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (i_core_finished) begin
                    load_out  = 1'b1;
                    state_nxt = S_QUERY_TX;
                end
            end
            S_QUERY_TX: begin
                if (!avm_read) begin
                    read_nxt = 1'b1;
                    addr_nxt = STATUS_BASE;
                end else if (xfer_done) begin
                    read_nxt = 1'b0;
                    if (avm_readdata[TX_OK_BIT]) state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!avm_write) begin
                    write_nxt = 1'b1;
                    addr_nxt  = TX_BASE;
                    wdata_nxt = {24'b0, out_reg[247:240]};
                end else if (xfer_done) begin
                    write_nxt = 1'b0;
                    shift_out = 1'b1;
                    if (cnt == OUT_LAST) begin
                        cnt_nxt   = '0;
                        phase_nxt = PH_A;
                        state_nxt = S_QUERY_RX;
                    end else begin
                        cnt_nxt   = cnt + 6'd1;
                        state_nxt = S_QUERY_TX;
                    end
                end
            end
            default: state_nxt = S_QUERY_RX;
        endcase
    end

    // Operand registers shift MSB-byte-first. The a register changes only in phase A, so n/d stay stable across blocks.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            n_reg   <= '0;
            d_reg   <= '0;
            a_reg   <= '0;
            out_reg <= '0;
        end else begin
            if (shift_in) begin
                case (phase)
                    PH_N:    n_reg <= {n_reg[247:0], avm_readdata[7:0]};
                    PH_D:    d_reg <= {d_reg[247:0], avm_readdata[7:0]};
                    PH_A:    a_reg <= {a_reg[247:0], avm_readdata[7:0]};
                    default: ;
                endcase
            end
            if (load_out) begin
                out_reg <= i_core_a_pow_d[247:0];
            end else if (shift_out) begin
                out_reg <= {out_reg[239:0], 8'h00};
            end
        end
    end

endmodule

// File: tb/tb_rsa_uart_wrapper.sv
// Randomized bench for rsa_uart_wrapper: a UART slave model with random stalls, plus a core stub that computes y^d mod n.
module tb_rsa_uart_wrapper;

    localparam logic [4:0] RXA    = 5'h00;
    localparam logic [4:0] TXA    = 5'h04;
    localparam logic [4:0] STATUS = 5'h08;

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   avm_address;
    logic         avm_read, avm_write, avm_waitrequest;
    logic [31:0]  avm_readdata, avm_writedata;
    logic         o_core_start, i_core_finished;
    logic [255:0] o_core_a, o_core_d, o_core_n, i_core_a_pow_d;

    always #5 clk = ~clk;

    rsa_uart_wrapper dut (
        .i_clk(clk), .i_rst(rst),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_d(o_core_d), .o_core_n(o_core_n),
        .i_core_a_pow_d(i_core_a_pow_d), .i_core_finished(i_core_finished)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // UART slave model
    logic [7:0]  rx_mem [0:1023];
    int          rx_wr = 0, rx_rd = 0, rx_polls = 0;
    logic [31:0] tx_q [$];
    int          tx_hold_req = 0, tx_blocked = 0;
    bit          in_xfer = 0;
    int          wait_left = 0;
    logic [4:0]  xfer_addr;

    // Core stub
    int           starts = 0, core_delay = 0, spur_req = 0, spur_done = 0;
    bit           core_busy = 0, stub_modexp = 0;
    logic [255:0] cap_n, cap_d, cap_a, stub_result;

    function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] e,
                                            input logic [255:0] m);
        logic [511:0] r, x, mm;
        mm = {256'b0, m};
        r  = 512'd1;
        x  = {256'b0, b} % mm;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[255:0];
    endfunction

    task automatic serve();
        bit rx_ok, tx_ok;
        if (avm_read && avm_address == STATUS) begin
            rx_ok = (rx_rd < rx_wr) && (rx_polls >= 5);
            if (!rx_ok && rx_rd < rx_wr) rx_polls++;
            tx_ok = (tx_blocked >= tx_hold_req);
            if (!tx_ok && rx_rd == rx_wr) tx_blocked++;
            avm_readdata = {24'($urandom), rx_ok, tx_ok, 6'($urandom)};
        end else if (avm_read && avm_address == RXA) begin
            chk("rx_avail", 256'(rx_rd < rx_wr), 256'd1);
            avm_readdata = {24'($urandom), rx_mem[rx_rd]};
            rx_rd++;
            rx_polls = 0;
        end else if (avm_write) begin
            chk("tx_addr", 256'(avm_address), 256'(TXA));
            chk("tx_gate", 256'(tx_blocked >= tx_hold_req), 256'd1);
            tx_q.push_back(avm_writedata);
        end else begin
            chk("rd_addr", 256'(avm_address), 256'(STATUS));
        end
    endtask

    task automatic slave_step();
        if (rst) begin
            in_xfer = 0;
            avm_waitrequest = 1'b0;
            rx_rd = rx_wr;
            rx_polls = 0;
            return;
        end
        if (avm_read || avm_write) begin
            chk("rw_excl", 256'(avm_read & avm_write), 256'd0);
            if (!in_xfer) begin
                in_xfer = 1;
                xfer_addr = avm_address;
                wait_left = $urandom_range(0, 3);
            end else begin
                chk("addr_hold", 256'(avm_address), 256'(xfer_addr));
            end
            if (wait_left > 0) begin
                wait_left--;
                avm_waitrequest = 1'b1;
                avm_readdata = $urandom;
            end else begin
                avm_waitrequest = 1'b0;
                in_xfer = 0;
                serve();
            end
        end else begin
            avm_waitrequest = 1'($urandom);
            avm_readdata = $urandom;
        end
    endtask

    task automatic stub_step();
        i_core_finished = 1'b0;
        if (rst) begin
            core_busy = 0;
            return;
        end
        if (o_core_start) begin
            starts++;
            cap_n = o_core_n;
            cap_d = o_core_d;
            cap_a = o_core_a;
            core_busy = 1;
            core_delay = $urandom_range(2, 12);
        end else if (core_busy) begin
            if (core_delay > 0) begin
                core_delay--;
            end else begin
                chk("n_stable", o_core_n, cap_n);
                chk("d_stable", o_core_d, cap_d);
                chk("a_stable", o_core_a, cap_a);
                i_core_a_pow_d = stub_modexp ? modexp(cap_a, cap_d, cap_n) : stub_result;
                i_core_finished = 1'b1;
                core_busy = 0;
            end
        end else if (spur_done < spur_req && avm_read && avm_address == RXA) begin
            i_core_a_pow_d = {8{$urandom}};
            i_core_finished = 1'b1;
            spur_done++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        slave_step();
        stub_step();
    endtask

    task automatic push_value(input logic [255:0] v);
        for (int i = 31; i >= 0; i--) begin
            rx_mem[rx_wr] = v[i*8 +: 8];
            rx_wr++;
        end
    endtask

    task automatic wait_tx(input int target, input int budget);
        int k = 0;
        while (tx_q.size() < target && k < budget) begin
            tick();
            k++;
        end
        chk("tx_timeout", 256'(tx_q.size() >= target), 256'd1);
    endtask

    task automatic check_plain(input string tag, input int base, input logic [255:0] x);
        for (int i = 0; i < 31; i++) begin
            if (base + i < tx_q.size())
                chk(tag, 256'(tx_q[base + i]), 256'({24'b0, x[(30 - i)*8 +: 8]}));
            else
                chk({tag, "_missing"}, 256'd0, 256'd1);
        end
    endtask

    logic [255:0] n1, d1, a1, a2, pat;
    int           k, s0, t0;

    initial begin
        rst = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        i_core_finished = 1'b0;
        i_core_a_pow_d = '0;
        stub_result = '0;
        repeat (3) tick();
        chk("rst_read", 256'(avm_read), 256'd0);
        chk("rst_write", 256'(avm_write), 256'd0);
        chk("rst_addr", 256'(avm_address), 256'd0);
        chk("rst_wdata", 256'(avm_writedata), 256'd0);
        chk("rst_start", 256'(o_core_start), 256'd0);
        chk("rst_n", o_core_n, 256'd0);
        chk("rst_d", o_core_d, 256'd0);
        chk("rst_a", o_core_a, 256'd0);
        rst = 1'b0;

        // First block: keys plus cipher, with TX held off for 20 polls
        n1 = {8{$urandom}};
        d1 = {8{$urandom}};
        a1 = {8{$urandom}};
        push_value(n1);
        push_value(d1);
        push_value(a1);
        pat = '0;
        for (int i = 0; i < 31; i++) pat[(30 - i)*8 +: 8] = 8'(8'hAB + i);
        stub_result = pat;
        tx_hold_req = 20;
        wait_tx(31, 20000);
        repeat (100) tick();
        chk("tx_count1", 256'(tx_q.size()), 256'd31);
        chk("starts1", 256'(starts), 256'd1);
        chk("core_n1", cap_n, n1);
        chk("core_d1", cap_d, d1);
        chk("core_a1", cap_a, a1);
        chk("tx_blocked", 256'(tx_blocked), 256'd20);
        check_plain("tx1", 0, pat);
        if (tx_q.size() >= 31) begin
            chk("tx1_first", 256'(tx_q[0]), 256'h000000AB);
            chk("tx1_last", 256'(tx_q[30]), 256'h000000C9);
        end

        // Second block: only a new cipher, with a spurious finish during reception
        a2 = {8{$urandom}};
        push_value(a2);
        spur_req = 1;
        stub_result = {8{$urandom}};
        wait_tx(62, 20000);
        repeat (100) tick();
        chk("rx_consumed2", 256'(rx_rd), 256'd128);
        chk("spurious_fired", 256'(spur_done), 256'd1);
        chk("starts2", 256'(starts), 256'd2);
        chk("core_n2", cap_n, n1);
        chk("core_d2", cap_d, d1);
        chk("core_a2", cap_a, a2);
        chk("tx_count2", 256'(tx_q.size()), 256'd62);
        check_plain("tx2", 31, stub_result);

        // Reset while byte 17 of d is being read, then a full reload
        push_value({8{$urandom}});
        push_value({8{$urandom}});
        push_value({8{$urandom}});
        k = 0;
        while (!(rx_rd == 128 + 48 && avm_read && avm_address == RXA) && k < 20000) begin
            tick();
            k++;
        end
        chk("reach_d17", 256'(k < 20000), 256'd1);
        rst = 1'b1;
        #1;
        chk("arst_read", 256'(avm_read), 256'd0);
        chk("arst_write", 256'(avm_write), 256'd0);
        chk("arst_start", 256'(o_core_start), 256'd0);
        chk("arst_n", o_core_n, 256'd0);
        chk("arst_d", o_core_d, 256'd0);
        chk("arst_a", o_core_a, 256'd0);
        repeat (2) tick();
        rst = 1'b0;
        push_value(256'd3233);
        push_value(256'd2753);
        push_value(256'd2790);
        stub_modexp = 1;
        s0 = starts;
        t0 = tx_q.size();
        wait_tx(t0 + 31, 20000);
        repeat (50) tick();
        chk("starts3", 256'(starts - s0), 256'd1);
        chk("core_n3", cap_n, 256'd3233);
        chk("core_d3", cap_d, 256'd2753);
        chk("core_a3", cap_a, 256'd2790);
        chk("tx_count3", 256'(tx_q.size() - t0), 256'd31);
        check_plain("tx3", t0, 256'd65);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
